// File: rtl/mgmt_pwr_seq_pkg.sv
// Purpose: shared state encoding, counter sizing and parameter checks for the power sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mgmt_pwr_seq_pkg;

    // Per-domain sequencer states; encodings are visible to software and debug.
    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_ISOREL   = 3'd2,
        ST_ON       = 3'd3,
        ST_SHUTDN   = 3'd4,
        ST_FAULT    = 3'd5
    } pwr_state_t;

    // Shared counter width: $clog2 of the larger interval, never below one bit.
    function automatic int cnt_width(input int deb_cycles, input int hold_cycles);
        int m;
        m = (deb_cycles > hold_cycles) ? deb_cycles : hold_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Both intervals must be at least one cycle long.
    function automatic bit params_legal(input int deb_cycles, input int hold_cycles);
        return (deb_cycles >= 1) && (hold_cycles >= 1);
    endfunction

endpackage

// File: rtl/mgmt_pwr_domain_seq.sv
// Purpose: one user power domain: 2-flop power-good synchronizer, debounce/hold counter and sequencing FSM.
// Latency: raw power-good rise to DEBOUNCE entry in 3 edges; isolation/reset release DEBOUNCE_CYCLES/+HOLD_CYCLES later.
// Backpressure: none; power loss preempts everything and parks the domain in FAULT until fault_clr.
module mgmt_pwr_domain_seq
    import mgmt_pwr_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pg_raw,
    input  logic sw_en,
    input  logic fault_clr,
    output logic pg_sync,
    output logic ena,
    output logic rstn,
    output logic fault,
    output logic fault_rise,
    output logic busy
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    if (!params_legal(DEBOUNCE_CYCLES, HOLD_CYCLES)) begin : g_bad_params
        $error("mgmt_pwr_domain_seq: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
    end

    logic          sync_q;
    pwr_state_t    state;
    pwr_state_t    nxt;
    logic [CW-1:0] cnt;

    // Two-stage synchronizer for the asynchronous level-shifted power-good flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 1'b0;
            pg_sync <= 1'b0;
        end else begin
            sync_q  <= pg_raw;
            pg_sync <= sync_q;
        end
    end

    // Next-state decode: power loss beats software disable beats counter expiry.
    always_comb begin
        nxt = state;
        case (state)
            ST_OFF:      if (pg_sync && sw_en) nxt = ST_DEBOUNCE;
            ST_DEBOUNCE: if (!(pg_sync && sw_en)) nxt = ST_OFF;
                         else if (cnt == DEB_LAST) nxt = ST_ISOREL;
            ST_ISOREL:   if (!pg_sync) nxt = ST_FAULT;
                         else if (!sw_en) nxt = ST_SHUTDN;
                         else if (cnt == HOLD_LAST) nxt = ST_ON;
            ST_ON:       if (!pg_sync) nxt = ST_FAULT;
                         else if (!sw_en) nxt = ST_SHUTDN;
            ST_SHUTDN:   if (!pg_sync) nxt = ST_FAULT;
                         else if (cnt == HOLD_LAST) nxt = ST_OFF;
            ST_FAULT:    if (fault_clr) nxt = ST_OFF;
            default:     nxt = ST_OFF;
        endcase
    end

    // State, saturating counter and all outputs registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            cnt        <= '0;
            ena        <= 1'b0;
            rstn       <= 1'b0;
            fault      <= 1'b0;
            fault_rise <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            ena        <= (nxt == ST_ISOREL) || (nxt == ST_ON) || (nxt == ST_SHUTDN);
            rstn       <= (nxt == ST_ON);
            fault      <= (nxt == ST_FAULT);
            fault_rise <= (nxt == ST_FAULT) && (state != ST_FAULT);
            busy       <= (nxt == ST_DEBOUNCE) || (nxt == ST_ISOREL) || (nxt == ST_SHUTDN);
        end
    end

endmodule

// File: rtl/mgmt_pwr_seq.sv
// Purpose: power-up/down sequencer for both user 3.3V domains; maps per-domain sequencers onto the shared ports.
// Latency: user_ena at 19 edges and user_rstn at 27 edges after raw power-good rise (default parameters).
// Backpressure: none; sw_en low drains a domain through SHUTDN, power loss forces FAULT immediately.
module mgmt_pwr_seq
    import mgmt_pwr_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic       caravel_clk,
    input  logic       caravel_rstn,
    input  logic       mprj_vdd_logic1,
    input  logic       mprj2_vdd_logic1,
    input  logic [1:0] sw_en,
    input  logic [1:0] fault_clr,
    output logic [1:0] user_ena,
    output logic [1:0] user_rstn,
    output logic [1:0] pg_sync,
    output logic [1:0] fault,
    output logic       busy,
    output logic       irq
);

    logic [1:0] pg_raw;
    logic [1:0] fault_rise;
    logic [1:0] dom_busy;

    // Bit 0 is the mprj domain, bit 1 the mprj2 domain.
    assign pg_raw = {mprj2_vdd_logic1, mprj_vdd_logic1};

    for (genvar d = 0; d < 2; d++) begin : g_dom
        mgmt_pwr_domain_seq #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_dom (
            .clk        (caravel_clk),
            .rst_n      (caravel_rstn),
            .pg_raw     (pg_raw[d]),
            .sw_en      (sw_en[d]),
            .fault_clr  (fault_clr[d]),
            .pg_sync    (pg_sync[d]),
            .ena        (user_ena[d]),
            .rstn       (user_rstn[d]),
            .fault      (fault[d]),
            .fault_rise (fault_rise[d]),
            .busy       (dom_busy[d])
        );
    end

    // Rising-edge flags are registered alongside fault, so irq lands on the same edge;
    // simultaneous faults in both domains merge into a single pulse.
    assign irq  = |fault_rise;
    assign busy = |dom_busy;

endmodule

// File: tb/tb_mgmt_pwr_seq.sv
module tb_mgmt_pwr_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       vdd1 = 1'b0;
    logic       vdd2 = 1'b0;
    logic [1:0] sw_en = 2'b00;
    logic [1:0] fault_clr = 2'b00;
    logic [1:0] user_ena;
    logic [1:0] user_rstn;
    logic [1:0] pg_sync;
    logic [1:0] fault;
    logic       busy;
    logic       irq;

    int checks = 0;
    int errors = 0;

    mgmt_pwr_seq #(
        .DEBOUNCE_CYCLES (16),
        .HOLD_CYCLES     (8)
    ) dut (
        .caravel_clk      (clk),
        .caravel_rstn     (rst_n),
        .mprj_vdd_logic1  (vdd1),
        .mprj2_vdd_logic1 (vdd2),
        .sw_en            (sw_en),
        .fault_clr        (fault_clr),
        .user_ena         (user_ena),
        .user_rstn        (user_rstn),
        .pg_sync          (pg_sync),
        .fault            (fault),
        .busy             (busy),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ena"},   {30'd0, user_ena},  32'd0);
        check({tag, "_rstn"},  {30'd0, user_rstn}, 32'd0);
        check({tag, "_pg"},    {30'd0, pg_sync},   32'd0);
        check({tag, "_fault"}, {30'd0, fault},     32'd0);
        check({tag, "_busy"},  {31'd0, busy},      32'd0);
        check({tag, "_irq"},   {31'd0, irq},       32'd0);
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        tick(2);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // 1. Power-up of domain 1
        sw_en = 2'b01;
        tick(2);
        vdd1 = 1'b1;
        tick(2);
        check("pu_pg_sync", pg_sync, 2'b01);
        tick(1);
        check("pu_busy_debounce", busy, 1'b1);
        tick(15);
        check("pu_ena_before", user_ena, 2'b00);
        tick(1);
        check("pu_ena_rise", user_ena, 2'b01);
        check("pu_rstn_held", user_rstn, 2'b00);
        tick(7);
        check("pu_rstn_before", user_rstn, 2'b00);
        tick(1);
        check("pu_rstn_rise", user_rstn, 2'b01);
        check("pu_ena_on", user_ena, 2'b01);
        check("pu_busy_idle", busy, 1'b0);

        // 2. Glitch on domain 2: ten cycles of power-good
        sw_en = 2'b11;
        vdd2 = 1'b1;
        tick(3);
        check("gl_busy_pulse", busy, 1'b1);
        tick(7);
        vdd2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("gl_ena_stable", user_ena, 2'b01);
            check("gl_rstn_stable", user_rstn, 2'b01);
            check("gl_fault", fault, 2'b00);
            check("gl_irq", irq, 1'b0);
        end
        check("gl_busy_end", busy, 1'b0);

        // 3. Power loss in ON for domain 2
        vdd2 = 1'b1;
        tick(27);
        check("pl_ena_on", user_ena, 2'b11);
        check("pl_rstn_on", user_rstn, 2'b11);
        vdd2 = 1'b0;
        tick(2);
        check("pl_ena_pre", user_ena, 2'b11);
        check("pl_irq_pre", irq, 1'b0);
        tick(1);
        check("pl_ena_drop", user_ena, 2'b01);
        check("pl_rstn_drop", user_rstn, 2'b01);
        check("pl_fault_set", fault, 2'b10);
        check("pl_irq_pulse", irq, 1'b1);
        tick(1);
        check("pl_irq_single", irq, 1'b0);
        check("pl_fault_sticky", fault, 2'b10);
        fault_clr = 2'b10;
        tick(1);
        fault_clr = 2'b00;
        check("pl_fault_clr", fault, 2'b00);
        tick(2);
        check("pl_off_ena", user_ena, 2'b01);
        check("pl_off_busy", busy, 1'b0);

        // 4. Software disable of domain 1 in ON
        sw_en = 2'b10;
        tick(1);
        check("sd_rstn_fall", user_rstn, 2'b00);
        check("sd_ena_hold", user_ena, 2'b01);
        check("sd_busy", busy, 1'b1);
        tick(7);
        check("sd_ena_before", user_ena, 2'b01);
        tick(1);
        check("sd_ena_fall", user_ena, 2'b00);
        check("sd_fault", fault, 2'b00);
        check("sd_busy_end", busy, 1'b0);
        check("sd_irq", irq, 1'b0);

        // 5. Power loss and sw_en low reaching the FSM together during ISOREL
        sw_en = 2'b01;
        tick(17);
        check("si_isorel_ena", user_ena, 2'b01);
        check("si_isorel_rstn", user_rstn, 2'b00);
        tick(1);
        vdd1 = 1'b0;
        tick(2);
        sw_en = 2'b00;
        check("si_ena_pre", user_ena, 2'b01);
        tick(1);
        check("si_ena_fault", user_ena, 2'b00);
        check("si_fault", fault, 2'b01);
        check("si_irq", irq, 1'b1);
        tick(1);
        check("si_irq_single", irq, 1'b0);
        fault_clr = 2'b01;
        tick(1);
        fault_clr = 2'b00;
        check("si_fault_clr", fault, 2'b00);

        // Both domains faulting on the same edge give one irq pulse
        sw_en = 2'b11;
        vdd1 = 1'b1;
        vdd2 = 1'b1;
        tick(27);
        check("dual_on", user_rstn, 2'b11);
        vdd1 = 1'b0;
        vdd2 = 1'b0;
        tick(3);
        check("dual_fault", fault, 2'b11);
        check("dual_irq", irq, 1'b1);
        tick(1);
        check("dual_irq_single", irq, 1'b0);
        fault_clr = 2'b11;
        tick(1);
        fault_clr = 2'b00;
        check("dual_clr", fault, 2'b00);

        // 6. Asynchronous reset in the middle of DEBOUNCE
        sw_en = 2'b01;
        vdd1 = 1'b1;
        tick(8);
        check("rs_busy_pre", busy, 1'b1);
        check("rs_pg_pre", pg_sync, 2'b01);
        rst_n = 1'b0;
        #1;
        check_all_zero("rs_async");
        tick(2);
        rst_n = 1'b1;
        tick(18);
        check("rs_ena_before", user_ena, 2'b00);
        tick(1);
        check("rs_ena_rise", user_ena, 2'b01);
        tick(7);
        check("rs_rstn_before", user_rstn, 2'b00);
        tick(1);
        check("rs_rstn_rise", user_rstn, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
